// File: rtl/seq_booth_mul_if.sv
// seq_booth_mul_if: start/busy/done handshake and operand/result bus
// for the sequential Booth multiplier.
interface seq_booth_mul_if #(
  parameter int N = 8,
  parameter int M = 8
);
  logic           start;
  logic           sign_mode;
  logic [N-1:0]   A;
  logic [M-1:0]   B;
  logic [N+M-1:0] Y;
  logic           busy;
  logic           done;

  modport master (
    output start, sign_mode, A, B,
    input  Y, busy, done
  );

  modport slave (
    input  start, sign_mode, A, B,
    output Y, busy, done
  );
endinterface

// File: rtl/seq_booth_mul.sv
// seq_booth_mul: sequential radix-2 Booth multiplier, one step per clock.
// Optional MUL_ZERO_SKIP_EN: zero operands complete in one edge.
module seq_booth_mul #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_booth_mul_if.slave   bus
);

  // P = {hi[N+2], b[M+1], q}; hi has a guard bit so hi - A never wraps
  localparam int W  = N + M + 4;
  localparam int CW = $clog2(M + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N+1:0]   a_q, a_d;
  logic [W-1:0]   p_q, p_d;
  logic [N+M-1:0] y_q, y_d;

  logic           accept;
  logic [N+1:0]   a_ext;
  logic [M:0]     b_ext;
  logic [W-1:0]   p_init;
  logic [N+1:0]   hi;
  logic [N+1:0]   sum;
  logic [1:0]     pair;
  logic [W-1:0]   p_step;

  assign accept = bus.start &&
                  (state_q == S_IDLE ||
                   state_q == S_DONE);

  assign a_ext = {{2{bus.sign_mode & bus.A[N-1]}},
                  bus.A};
  assign b_ext = {bus.sign_mode & bus.B[M-1],
                  bus.B};
  assign p_init = {{(N+2){1'b0}}, b_ext, 1'b0};

  assign hi   = p_q[W-1:M+2];
  assign pair = p_q[1:0];

  always_comb begin
    sum = hi;
    unique case (1'b1)
      pair == 2'b01: sum = hi + a_q;
      pair == 2'b10: sum = hi - a_q;
      default:       sum = hi;
    endcase
  end

  assign p_step = {sum[N+1], sum, p_q[M+1:1]};

`ifdef MUL_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (bus.A == '0) ||
                   (bus.B == '0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    y_d     = y_q;

    case (state_q)
      S_RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          y_d     = p_step[N+M:1];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: ;
    endcase

    if (accept) begin
      a_d     = a_ext;
      p_d     = p_init;
      cnt_d   = CW'(M);
      state_d = S_RUN;
`ifdef MUL_ZERO_SKIP_EN
      if (zero_op) begin
        a_d     = '0;
        p_d     = '0;
        cnt_d   = '0;
        y_d     = '0;
        state_d = S_DONE;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      p_q     <= p_d;
      y_q     <= y_d;
    end
  end

  assign bus.Y    = y_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);

  a_busy_done_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bus.busy && bus.done));

endmodule

// File: tb/tb_seq_booth_mul.sv
// tb_seq_booth_mul: scoreboard bench for seq_booth_mul (N=M=8),
// covering latency, signed corners, handshake, reset and zero operands.
module tb_seq_booth_mul;

  localparam int N = 8;
  localparam int M = 8;

`ifdef MUL_ZERO_SKIP_EN
  localparam int ZLAT  = 0;
  localparam int ZBUSY = 0;
`else
  localparam int ZLAT  = 9;
  localparam int ZBUSY = 9;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [15:0] sb[$];

  seq_booth_mul_if #(.N(N), .M(M)) bi ();

  seq_booth_mul #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       m
  );
    int x;
    int y;
    x = m ? int'($signed(a)) : int'({24'd0, a});
    y = m ? int'($signed(b)) : int'({24'd0, b});
    return 16'(x * y);
  endfunction

  task automatic run_op(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       m,
    output int         lat,
    output int         bc,
    output bit         to
  );
    @(negedge clk);
    bi.start     = 1'b1;
    bi.A         = a;
    bi.B         = b;
    bi.sign_mode = m;
    sb.push_back(model(a, b, m));
    @(negedge clk);
    bi.start     = 1'b0;
    bi.A         = 8'($urandom);
    bi.B         = 8'($urandom);
    bi.sign_mode = 1'($urandom);
    lat = 0;
    bc  = 0;
    to  = 1'b0;
    while (!bi.done) begin
      if (bi.busy) bc++;
      if (lat > 40) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    bi.start     = 1'b0;
    bi.sign_mode = 1'b0;
    bi.A         = '0;
    bi.B         = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if (bi.Y !== 16'h0) begin
      n_err++;
      $display("FAIL reset_y: got %h want 0000", bi.Y);
    end
    n_cmp++;
    if (bi.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", bi.busy);
    end
    n_cmp++;
    if (bi.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got %b want 0", bi.done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bi.done !== 1'b0 || bi.busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy %b done %b want 0 0",
               bi.busy, bi.done);
    end
  endtask

  task automatic test_unsigned();
    int lat, bc;
    bit to;
    logic [15:0] exp;
    run_op(8'd255, 8'd255, 1'b0, lat, bc, to);
    exp = sb.pop_front();
    n_cmp++;
    if (to || bi.Y !== exp) begin
      n_err++;
      $display("FAIL unsigned_y: got %h want %h", bi.Y, exp);
    end
    n_cmp++;
    if (bi.Y !== 16'hFE01) begin
      n_err++;
      $display("FAIL unsigned_const: got %h want fe01", bi.Y);
    end
    n_cmp++;
    if (lat !== 9) begin
      n_err++;
      $display("FAIL unsigned_latency: got %0d want 9", lat);
    end
    n_cmp++;
    if (bc !== 9) begin
      n_err++;
      $display("FAIL unsigned_busy_cycles: got %0d want 9", bc);
    end
  endtask

  task automatic test_signed();
    logic [7:0]  ta[3] = '{8'h80, 8'hFF, 8'h80};
    logic [7:0]  tb[3] = '{8'h80, 8'h7F, 8'h7F};
    logic [15:0] ty[3] = '{16'h4000, 16'hFF81, 16'hC080};
    int lat, bc;
    bit to;
    logic [15:0] exp;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b1, lat, bc, to);
      exp = sb.pop_front();
      n_cmp++;
      if (to || bi.Y !== exp) begin
        n_err++;
        $display("FAIL signed_y[%0d]: got %h want %h", i, bi.Y, exp);
      end
      n_cmp++;
      if (bi.Y !== ty[i]) begin
        n_err++;
        $display("FAIL signed_const[%0d]: got %h want %h",
                 i, bi.Y, ty[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int k;
    int extra;
    logic [15:0] exp;
    @(negedge clk);
    bi.start = 1'b1;
    bi.A = 8'd3;
    bi.B = 8'd5;
    bi.sign_mode = 1'b0;
    sb.push_back(model(8'd3, 8'd5, 1'b0));
    @(negedge clk);
    bi.start = 1'b0;
    k = 0;
    repeat (3) begin
      @(negedge clk);
      k++;
    end
    bi.start = 1'b1;
    bi.A = 8'd7;
    bi.B = 8'd9;
    @(negedge clk);
    k++;
    bi.start = 1'b0;
    while (!bi.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    exp = sb.pop_front();
    n_cmp++;
    if (bi.done !== 1'b1 || bi.Y !== exp) begin
      n_err++;
      $display("FAIL ignore_mid_start_y: got %h want %h", bi.Y, exp);
    end
    n_cmp++;
    if (k !== 9) begin
      n_err++;
      $display("FAIL ignore_mid_start_lat: got %0d want 9", k);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bi.done) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL ignore_mid_start_extra_done: got %0d want 0",
               extra);
    end
  endtask

  task automatic test_back_to_back();
    int k, k1, k2;
    logic [15:0] exp;
    @(negedge clk);
    bi.start = 1'b1;
    bi.A = 8'h12;
    bi.B = 8'h34;
    bi.sign_mode = 1'b0;
    sb.push_back(model(8'h12, 8'h34, 1'b0));
    @(negedge clk);
    bi.A = 8'hF3;
    bi.B = 8'h85;
    bi.sign_mode = 1'b1;
    sb.push_back(model(8'hF3, 8'h85, 1'b1));
    k = 0;
    while (!bi.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    k1 = k;
    exp = sb.pop_front();
    n_cmp++;
    if (bi.done !== 1'b1 || bi.Y !== exp) begin
      n_err++;
      $display("FAIL b2b_first_y: got %h want %h", bi.Y, exp);
    end
    @(negedge clk);
    k++;
    bi.start = 1'b0;
    n_cmp++;
    if (bi.busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_accept: busy %b want 1", bi.busy);
    end
    while (!bi.done && k < 80) begin
      @(negedge clk);
      k++;
    end
    k2 = k;
    exp = sb.pop_front();
    n_cmp++;
    if (bi.done !== 1'b1 || bi.Y !== exp) begin
      n_err++;
      $display("FAIL b2b_second_y: got %h want %h", bi.Y, exp);
    end
    n_cmp++;
    if (k2 - k1 !== 10) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d want 10", k2 - k1);
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    @(negedge clk);
    bi.start = 1'b1;
    bi.A = 8'd100;
    bi.B = 8'd200;
    bi.sign_mode = 1'b0;
    sb.push_back(model(8'd100, 8'd200, 1'b0));
    @(negedge clk);
    bi.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    n_cmp++;
    if (bi.Y !== 16'h0) begin
      n_err++;
      $display("FAIL midreset_y: got %h want 0000", bi.Y);
    end
    n_cmp++;
    if (bi.busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_busy: got %b want 0", bi.busy);
    end
    n_cmp++;
    if (bi.done !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_done: got %b want 0", bi.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (bi.done || bi.busy) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL midreset_no_done: got %0d active cycles want 0",
               extra);
    end
  endtask

  task automatic test_zero();
    logic [7:0] za[4] = '{8'h00, 8'h00, 8'hAB, 8'h5C};
    logic [7:0] zb[4] = '{8'hAB, 8'hAB, 8'h00, 8'h00};
    logic       zm[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat, bc;
    bit to;
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) begin
      run_op(za[i], zb[i], zm[i], lat, bc, to);
      exp = sb.pop_front();
      n_cmp++;
      if (to || bi.Y !== exp || bi.Y !== 16'h0) begin
        n_err++;
        $display("FAIL zero_y[%0d]: got %h want %h", i, bi.Y, exp);
      end
      n_cmp++;
      if (lat !== ZLAT) begin
        n_err++;
        $display("FAIL zero_lat[%0d]: got %0d want %0d",
                 i, lat, ZLAT);
      end
      n_cmp++;
      if (bc !== ZBUSY) begin
        n_err++;
        $display("FAIL zero_busy[%0d]: got %0d want %0d",
                 i, bc, ZBUSY);
      end
    end
  endtask

  task automatic test_random();
    int lat, bc, want_lat;
    bit to;
    logic [7:0] a, b;
    logic m;
    logic [15:0] exp;
    for (int i = 0; i < 500; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      m = 1'($urandom);
      if (i % 50 == 0) a = 8'h80;
      if (i % 70 == 0) b = 8'hFF;
      run_op(a, b, m, lat, bc, to);
      exp = sb.pop_front();
      want_lat = (a == 8'h0 || b == 8'h0) ? ZLAT : 9;
      n_cmp++;
      if (to || bi.Y !== exp) begin
        n_err++;
        $display("FAIL random_y[%0d]: a=%h b=%h s=%b got %h want %h",
                 i, a, b, m, bi.Y, exp);
      end
      n_cmp++;
      if (lat !== want_lat) begin
        n_err++;
        $display("FAIL random_lat[%0d]: got %0d want %0d",
                 i, lat, want_lat);
      end
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0",
               sb.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
